// File: rtl/dq_read_capture_pkg.sv
// Shared definitions for the DDR3 read capture path: FSM encoding and
// the DQS preamble recognition rule.
package dq_read_capture_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    SECOND = 2'd2
  } state_t;

  localparam int CNT_W = 8;

  // Toggle pattern listed earliest-first, i.e. h[4+k], h[5+k], h[6+k], h[7+k]
  localparam logic [3:0] DQS_PREAMBLE = 4'b1010;
  // DQS must be low in the sample just before the first rising edge
  localparam logic       DQS_PRE_EDGE = 1'b0;

  // w = h[7+k:3+k] of the DQS history
  function automatic logic is_preamble(input logic [4:0] w);
    return (w[0] == DQS_PRE_EDGE) && ({w[1], w[2], w[3], w[4]} == DQS_PREAMBLE);
  endfunction

endpackage

// File: rtl/dq_lane_align.sv
// Per-pin two-word history plus the 4:1 bit-offset slice selector.
module dq_lane_align (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  din,
  input  logic [1:0]  k,
  output logic [11:0] hist,
  output logic [3:0]  slice
);

  logic [3:0] prev;
  logic [3:0] prev2;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= '0;
      prev2 <= '0;
    end else begin
      prev  <= din;
      prev2 <= prev;
    end
  end

  assign hist = {din, prev, prev2};

  always_comb begin
    slice = hist[7:4];
    unique case (k)
      2'd0: slice = hist[7:4];
      2'd1: slice = hist[8:5];
      2'd2: slice = hist[9:6];
      2'd3: slice = hist[10:7];
      default: slice = hist[7:4];
    endcase
  end

endmodule

// File: rtl/dq_read_capture.sv
// DDR3 read capture: locks on the DQS preamble after each read command and
// assembles one BL8 burst per DQ lane.
module dq_read_capture #(
  parameter int DQ_WIDTH = 8,
  parameter int WINDOW   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DQ_WIDTH-1:0] din_dq,
  input  logic [3:0]            din_dqs,
  input  logic                  rd_start,
  output logic                  busy,
  output logic [8*DQ_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [1:0]            rd_offset,
  output logic                  rd_timeout,
  output logic                  rd_overrun
);
  import dq_read_capture_pkg::*;

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        win_cnt;
  logic [11:0]             dqs_hist;
  logic [3:0]              dqs_slice;
  logic [12*DQ_WIDTH-1:0]  dq_hist;
  logic [4*DQ_WIDTH-1:0]   dq_slice;
  logic [4*DQ_WIDTH-1:0]   beats_lo_p1;
  logic [8*DQ_WIDTH-1:0]   burst;
  logic [1:0]              k_hit, k_sel;
  logic                    hit, start_ok, tmo;

  // History taps are only consumed on the strobe pin, the slice only on DQ
  logic unused_taps;
  assign unused_taps = ^{dq_hist, dqs_slice};

  dq_lane_align u_dqs_align (
    .clk   (clk),
    .rst   (rst),
    .din   (din_dqs),
    .k     (k_sel),
    .hist  (dqs_hist),
    .slice (dqs_slice)
  );

  for (genvar i = 0; i < DQ_WIDTH; i++) begin : g_lane
    dq_lane_align u_align (
      .clk   (clk),
      .rst   (rst),
      .din   (din_dq[4*i +: 4]),
      .k     (k_sel),
      .hist  (dq_hist[12*i +: 12]),
      .slice (dq_slice[4*i +: 4])
    );
  end

  // Descending scan so the smallest matching offset is the one that sticks
  always_comb begin
    hit   = 1'b0;
    k_hit = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (is_preamble(dqs_hist[k+3 +: 5])) begin
        hit   = 1'b1;
        k_hit = 2'(k);
      end
    end
  end

  assign k_sel    = (state == SEARCH) ? k_hit : rd_offset;
  assign start_ok = rd_start && (state == IDLE) && !rd_valid && !rd_timeout;
  assign tmo      = (state == SEARCH) && !hit && (win_cnt == WIN_LAST);
  assign busy     = (state != IDLE);

  always_comb begin
    burst = '0;
    for (int i = 0; i < DQ_WIDTH; i++)
      burst[8*i +: 8] = {dq_slice[4*i +: 4], beats_lo_p1[4*i +: 4]};
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = SEARCH;
      SEARCH:  if (hit) state_nxt = SECOND;
               else if (tmo) state_nxt = IDLE;
      SECOND:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      win_cnt    <= '0;
      rd_valid   <= 1'b0;
      rd_timeout <= 1'b0;
      rd_overrun <= 1'b0;
      rd_offset  <= 2'd0;
      rd_data    <= '0;
    end else begin
      state      <= state_nxt;
      rd_valid   <= (state == SECOND);
      rd_timeout <= tmo;
      rd_overrun <= rd_start && !start_ok;
      if (start_ok)
        win_cnt <= '0;
      else if (state == SEARCH)
        win_cnt <= win_cnt + 1'b1;
      if ((state == SEARCH) && hit)
        rd_offset <= k_hit;
      if (state == SECOND)
        rd_data <= burst;
    end
  end

  // p1: first half of the burst, captured in the lock cycle
  always_ff @(posedge clk) begin
    if ((state == SEARCH) && hit)
      beats_lo_p1 <= dq_slice;
  end

endmodule

// File: tb/tb_dq_read_capture.sv
// Directed bench for dq_read_capture: a serial-bitstream model predicts every
// output each cycle, and literal burst values pin the model.
module tb_dq_read_capture;

  localparam int DQ_WIDTH = 8;
  localparam int WINDOW   = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [4*DQ_WIDTH-1:0] din_dq;
  logic [3:0]            din_dqs;
  logic                  rd_start;
  logic                  busy;
  logic [8*DQ_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [1:0]            rd_offset;
  logic                  rd_timeout;
  logic                  rd_overrun;

  dq_read_capture #(.DQ_WIDTH(DQ_WIDTH), .WINDOW(WINDOW)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_dq     (din_dq),
    .din_dqs    (din_dqs),
    .rd_start   (rd_start),
    .busy       (busy),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_offset  (rd_offset),
    .rd_timeout (rd_timeout),
    .rd_overrun (rd_overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each pin viewed as one serial bitstream: stream position 4*cycle + bit
  bit [31:0] dq_log  [0:1023];
  bit [3:0]  dqs_log [0:1023];
  int        cyc = 2;
  bit        model_ready = 0;
  bit        reading = 0, burst_due = 0;
  int        start_cyc, lock_k;
  bit        e_busy = 0, e_valid = 0, e_timeout = 0, e_overrun = 0;
  bit [1:0]  e_offset = 0;
  bit [63:0] e_data = 0;

  function automatic bit pin_bit(input int pin, input int pos);
    if (pin == DQ_WIDTH) return dqs_log[pos / 4][pos % 4];
    return dq_log[pos / 4][4*pin + (pos % 4)];
  endfunction

  // Preamble: DQS reads 0,1,0,1,0 in time order starting at the pre-edge bit
  function automatic bit preamble_at(input int c, input int k);
    int base;
    base = 4*(c-2) + 3 + k;
    return pin_bit(DQ_WIDTH, base) == 0 && pin_bit(DQ_WIDTH, base+1) == 1 &&
           pin_bit(DQ_WIDTH, base+2) == 0 && pin_bit(DQ_WIDTH, base+3) == 1 &&
           pin_bit(DQ_WIDTH, base+4) == 0;
  endfunction

  always @(posedge clk) begin : model
    bit busy_now;
    dq_log[cyc]  = din_dq;
    dqs_log[cyc] = din_dqs;
    if (rst) begin
      dq_log[cyc] = 0;   dqs_log[cyc] = 0;
      dq_log[cyc-1] = 0; dqs_log[cyc-1] = 0;
      reading = 0; burst_due = 0;
      e_busy = 0; e_valid = 0; e_timeout = 0; e_overrun = 0;
      e_offset = 0; e_data = 0;
    end else begin
      busy_now  = e_busy | e_valid | e_timeout;
      e_valid   = 0;
      e_timeout = 0;
      e_overrun = rd_start & busy_now;
      if (burst_due) begin
        // lock was in cyc-1: beat b of a lane sits at 4*(lock-1)+k+b
        for (int i = 0; i < DQ_WIDTH; i++)
          for (int b = 0; b < 8; b++)
            e_data[8*i + b] = pin_bit(i, 4*(cyc-2) + lock_k + b);
        e_valid   = 1;
        e_busy    = 0;
        burst_due = 0;
      end else if (reading) begin
        for (int k = 0; k < 4; k++)
          if (!burst_due && preamble_at(cyc, k)) begin
            burst_due = 1;
            lock_k    = k;
            e_offset  = 2'(k);
          end
        if (burst_due) reading = 0;
        else if (cyc - start_cyc == WINDOW) begin
          e_timeout = 1;
          reading   = 0;
          e_busy    = 0;
        end
      end else if (rd_start && !busy_now) begin
        reading   = 1;
        start_cyc = cyc;
        e_busy    = 1;
      end
    end
    cyc++;
    model_ready = 1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      chk("busy",       busy,       e_busy);
      chk("rd_valid",   rd_valid,   e_valid);
      chk("rd_timeout", rd_timeout, e_timeout);
      chk("rd_overrun", rd_overrun, e_overrun);
      chk("rd_offset",  rd_offset,  e_offset);
      chk("rd_data",    rd_data,    e_data);
    end
  end

  int        valid_cnt = 0, tmo_cnt = 0, ovr_cnt = 0;
  logic [63:0] last_data = '0;
  logic [1:0]  last_off  = '0;

  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      valid_cnt++;
      last_data = rd_data;
      last_off  = rd_offset;
    end
    if (rd_timeout === 1'b1) tmo_cnt++;
    if (rd_overrun === 1'b1) ovr_cnt++;
  end

  task automatic step(input logic st, input logic r, input logic [3:0] s, input logic [31:0] q);
    @(posedge clk);
    #1;
    rd_start = st;
    rst      = r;
    din_dqs  = s;
    din_dq   = q;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; rd_start = 1'b0; din_dqs = 4'h0; din_dq = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",  busy,    64'd0);
    chk("reset_data",  rd_data, 64'd0);
    chk("reset_valid", rd_valid, 64'd0);
    idle(2);

    // k=0 lock (k=2 also matches); lane0 burst 8'hC3
    step(1, 0, 4'b0000, 32'h0);
    step(0, 0, 4'b0000, 32'h0);
    step(0, 0, 4'b0101, 32'h1234_5673);
    step(0, 0, 4'b0101, 32'h9ABC_DEFC);
    step(0, 0, 4'b0000, 32'h5555_AAAA);
    idle(3);
    chk("k0_count",  valid_cnt,       64'd1);
    chk("k0_lane0",  last_data[7:0],  64'hC3);
    chk("k0_offset", last_off,        64'd0);

    // k=2 lock; lane0 burst 8'hA5 straddles three words
    step(1, 0, 4'b0000, 32'h0);
    step(0, 0, 4'b0000, 32'h0);
    step(0, 0, 4'b0100, 32'h0F1E_2D34);
    step(0, 0, 4'b0101, 32'h8765_4329);
    step(0, 0, 4'b0000, 32'hFEDC_BA92);
    idle(3);
    chk("k2_count",  valid_cnt,      64'd2);
    chk("k2_lane0",  last_data[7:0], 64'hA5);
    chk("k2_offset", last_off,       64'd2);

    // no preamble at all
    step(1, 0, 4'b0000, 32'h0);
    idle(20);
    chk("tmo_count",  tmo_cnt,   64'd1);
    chk("tmo_novld",  valid_cnt, 64'd2);
    chk("tmo_offset", rd_offset, 64'd2);
    chk("tmo_busy",   busy,      64'd0);

    // rd_start during SEARCH and again on the rd_valid cycle
    step(1, 0, 4'b0000, 32'h0);
    step(0, 0, 4'b0000, 32'h0);
    step(1, 0, 4'b0101, 32'h1111_2222);
    step(0, 0, 4'b0101, 32'h3333_4444);
    step(0, 0, 4'b0000, 32'h5555_6666);
    step(1, 0, 4'b0000, 32'h0);
    idle(20);
    chk("ovr_valid_once", valid_cnt, 64'd3);
    chk("ovr_pulses",     ovr_cnt,   64'd2);
    chk("ovr_no_tmo",     tmo_cnt,   64'd1);

    // k=1 and k=3 both match: smallest wins
    step(1, 0, 4'b0000, 32'h0);
    step(0, 0, 4'b0000, 32'h0);
    step(0, 0, 4'b1010, 32'hA1B2_C3D4);
    step(0, 0, 4'b0010, 32'hE5F6_0718);
    step(0, 0, 4'b0000, 32'h293A_4B5C);
    idle(3);
    chk("multi_offset", last_off, 64'd1);

    // rst in the SECOND cycle drops the burst
    step(1, 0, 4'b0000, 32'h0);
    step(0, 0, 4'b0000, 32'h0);
    step(0, 0, 4'b0101, 32'h7777_8888);
    step(0, 0, 4'b0101, 32'h9999_AAAA);
    step(0, 1, 4'b0000, 32'hBBBB_CCCC);
    step(0, 0, 4'b0000, 32'h0);
    chk("rst_busy", busy, 64'd0);
    idle(3);
    chk("rst_novld", valid_cnt, 64'd4);

    // normal k=3 read afterwards; lane0 burst 8'h5A
    step(1, 0, 4'b0000, 32'h0);
    step(0, 0, 4'b0000, 32'h0);
    step(0, 0, 4'b1000, 32'hC0FF_EE00);
    step(0, 0, 4'b0010, 32'h1357_9BDD);
    step(0, 0, 4'b0000, 32'h2468_ACE2);
    idle(3);
    chk("post_rst_count",  valid_cnt,      64'd5);
    chk("post_rst_lane0",  last_data[7:0], 64'h5A);
    chk("post_rst_offset", last_off,       64'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
